// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the immediate and branch/jump target for each incoming
// instruction, then buffers the result in a 2-entry FIFO so the downstream stage sees
// purely registered outputs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               discard every buffered entry (has priority over push/pop)
//   in_valid/in_ready   upstream handshake; in_ready depends on registered state only
//   instr, pc, imm_src  raw instruction word, its address, immediate format select
//   out_valid/out_ready downstream handshake for the head entry
//   imm_ext, pc_target  head entry's extended immediate and pc + imm_ext
//   imm_err             head entry used the illegal format (imm_src = 3'b111)
//   err_count           saturating count of accepted illegal-format entries
module imm_decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     pc,
  input  logic [2:0]          imm_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     imm_ext,
  output logic [XLEN-1:0]     pc_target,
  output logic                imm_err,
  output logic [ERRCNT_W-1:0] err_count
);

  // FIFO storage and control
  logic [XLEN-1:0] imm_mem_q [2];
  logic [XLEN-1:0] imm_mem_d [2];
  logic [XLEN-1:0] tgt_mem_q [2];
  logic [XLEN-1:0] tgt_mem_d [2];
  logic [1:0]      err_mem_q, err_mem_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;

  // Output registers: hold the current head, and keep their last value when empty
  logic [XLEN-1:0]     imm_out_q, imm_out_d;
  logic [XLEN-1:0]     tgt_out_q, tgt_out_d;
  logic                err_out_q, err_out_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic            push, pop;
  logic [31:0]     imm32;
  logic            sext, illegal;
  logic [XLEN-1:0] imm_new, tgt_new;

  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Immediate decode. Signed formats already carry instr[31] in imm32[31], so the
  // final widening to XLEN only has to replicate that bit.
  always_comb begin
    imm32   = '0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (imm_src)
      3'b000: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        sext  = 1'b1;
      end
      3'b001: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        sext  = 1'b1;
      end
      3'b010: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        sext  = 1'b1;
      end
      3'b011: begin
        imm32 = {instr[31:12], 12'b0};
        sext  = 1'b1;
      end
      3'b100: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        sext  = 1'b1;
      end
      3'b101: imm32 = {27'b0, instr[19:15]};
      3'b110: imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default: illegal = 1'b1;
    endcase
    imm_new = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    tgt_new = pc + imm_new;
  end

  // FIFO next state; flush wins over any concurrent push or pop
  always_comb begin
    imm_mem_d = imm_mem_q;
    tgt_mem_d = tgt_mem_q;
    err_mem_d = err_mem_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        imm_mem_d[wr_ptr_q] = imm_new;
        tgt_mem_d[wr_ptr_q] = tgt_new;
        err_mem_d[wr_ptr_q] = illegal;
        wr_ptr_d            = ~wr_ptr_q;
        if (illegal && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Load the output registers from the next-cycle head so the result is visible one
  // cycle after enqueue without any combinational path from the FIFO to the outputs.
  always_comb begin
    imm_out_d = imm_out_q;
    tgt_out_d = tgt_out_q;
    err_out_d = err_out_q;
    if (cnt_d != 2'd0) begin
      imm_out_d = imm_mem_d[rd_ptr_d];
      tgt_out_d = tgt_mem_d[rd_ptr_d];
      err_out_d = err_mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_mem_q[0] <= '0;
      imm_mem_q[1] <= '0;
      tgt_mem_q[0] <= '0;
      tgt_mem_q[1] <= '0;
      err_mem_q    <= '0;
      cnt_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      imm_out_q    <= '0;
      tgt_out_q    <= '0;
      err_out_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      imm_mem_q <= imm_mem_d;
      tgt_mem_q <= tgt_mem_d;
      err_mem_q <= err_mem_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      imm_out_q <= imm_out_d;
      tgt_out_q <= tgt_out_d;
      err_out_q <= err_out_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign imm_ext   = imm_out_q;
  assign pc_target = tgt_out_q;
  assign imm_err   = err_out_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit and a 64-bit instance share every input. Each
// accepted push queues hand-computed expectations for both widths; two monitors pop
// and compare whenever their instance completes an output transfer.
module tb_imm_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [2:0]  imm_src;

  logic        rdy32, vld32, ierr32;
  logic [31:0] imm32, tgt32;
  logic [7:0]  ecnt32;
  logic        rdy64, vld64, ierr64;
  logic [63:0] imm64, tgt64;
  logic [7:0]  ecnt64;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks   = 0;
  int   errors   = 0;
  int   exp_ecnt = 0;
  bit   bp_done;

  imm_decode_stage #(.XLEN(32), .ERRCNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .pc(pc[31:0]), .imm_src(imm_src), .out_valid(vld32),
    .out_ready(out_ready), .imm_ext(imm32), .pc_target(tgt32), .imm_err(ierr32),
    .err_count(ecnt32)
  );

  imm_decode_stage #(.XLEN(64), .ERRCNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .pc(pc), .imm_src(imm_src), .out_valid(vld64),
    .out_ready(out_ready), .imm_ext(imm64), .pc_target(tgt64), .imm_err(ierr64),
    .err_count(ecnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: a transfer completes at the next posedge when valid & ready & !flush
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && vld32 && out_ready && !flush) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d32_unexpected: got imm %0h expected no entry", imm32);
      end else begin
        e = q32.pop_front();
        chk("d32_imm", {32'b0, imm32}, {32'b0, e.imm[31:0]});
        chk("d32_tgt", {32'b0, tgt32}, {32'b0, e.tgt[31:0]});
        chk("d32_err", {63'b0, ierr32}, {63'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && vld64 && out_ready && !flush) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d64_unexpected: got imm %0h expected no entry", imm64);
      end else begin
        e = q64.pop_front();
        chk("d64_imm", imm64, e.imm);
        chk("d64_tgt", tgt64, e.tgt);
        chk("d64_err", {63'b0, ierr64}, {63'b0, e.err});
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the entry.
  task automatic push(input logic [31:0] i, input logic [63:0] p, input logic [2:0] s,
                      input logic [31:0] i32, input logic [31:0] t32,
                      input logic [63:0] i64, input logic [63:0] t64);
    int n;
    bit done;
    exp_t e;
    n        = 0;
    done     = 1'b0;
    instr    = i;
    pc       = p;
    imm_src  = s;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rdy32 !== rdy64) begin
        checks++;
        errors++;
        $display("FAIL in_ready_match: got d32 %0b d64 %0b expected equal", rdy32, rdy64);
      end
      if (rdy32) begin
        e.err = (s == 3'b111);
        e.imm = {32'b0, i32};
        e.tgt = {32'b0, t32};
        q32.push_back(e);
        e.imm = i64;
        e.tgt = t64;
        q64.push_back(e);
        if (e.err && exp_ecnt < 255) exp_ecnt++;
        done = 1'b1;
      end else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got in_ready 0 for %0d cycles expected 1", n);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    pc        = '0;
    imm_src   = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {62'b0, rdy32, rdy64}, 64'h3);
    chk("rst_out_valid", {62'b0, vld32, vld64}, 64'h0);
    chk("rst_imm", {imm32, imm64[31:0]} | imm64, 64'h0);
    chk("rst_tgt", {tgt32, tgt64[31:0]} | tgt64, 64'h0);
    chk("rst_err", {46'b0, ierr32, ierr64, ecnt32, ecnt64}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed formats; first push also checks one-cycle latency after reset release
    push(32'hFFF00093, 64'h100, 3'b000, 32'hFFFFFFFF, 32'h000000FF,
         64'hFFFFFFFFFFFFFFFF, 64'hFF);
    chk("latency_valid", {62'b0, vld32, vld64}, 64'h3);
    push(32'hFE112E23, 64'h200, 3'b001, 32'hFFFFFFFC, 32'h1FC,
         64'hFFFFFFFFFFFFFFFC, 64'h1FC);
    push(32'hFE000EE3, 64'h1000, 3'b010, 32'hFFFFFFFC, 32'hFFC,
         64'hFFFFFFFFFFFFFFFC, 64'hFFC);
    push(32'h12345037, 64'h10, 3'b011, 32'h12345000, 32'h12345010,
         64'h12345000, 64'h12345010);
    push(32'h80000037, 64'h10, 3'b011, 32'h80000000, 32'h80000010,
         64'hFFFFFFFF80000000, 64'hFFFFFFFF80000010);
    push(32'h0080006F, 64'h40, 3'b100, 32'h8, 32'h48, 64'h8, 64'h48);
    push(32'hFFDFF06F, 64'h100, 3'b100, 32'hFFFFFFFC, 32'hFC,
         64'hFFFFFFFFFFFFFFFC, 64'hFC);
    push(32'hFFFF8073, 64'h0, 3'b101, 32'h1F, 32'h1F, 64'h1F, 64'h1F);
    push(32'h03F00013, 64'h1000, 3'b110, 32'h1F, 32'h101F, 64'h3F, 64'h103F);
    push(32'hFFFFFFFF, 64'h55, 3'b111, 32'h0, 32'h55, 64'h0, 64'h55);
    push(32'h01000093, 64'hFFFFFFF0, 3'b000, 32'h10, 32'h0, 64'h10, 64'h100000000);
    idle(1);
    drain();
    chk("ecnt_after_vectors", {ecnt32, ecnt64}, {exp_ecnt[7:0], exp_ecnt[7:0]});

    // Backpressure: third entry must wait while the head is held
    out_ready = 1'b0;
    bp_done   = 1'b0;
    fork
      begin
        push(32'h00100093, 64'h0, 3'b000, 32'h1, 32'h1, 64'h1, 64'h1);
        push(32'h00200093, 64'h0, 3'b000, 32'h2, 32'h2, 64'h2, 64'h2);
        push(32'h00300093, 64'h0, 3'b000, 32'h3, 32'h3, 64'h3, 64'h3);
        in_valid = 1'b0;
        bp_done  = 1'b1;
      end
    join_none
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("bp_in_ready", {62'b0, rdy32, rdy64}, 64'h0);
    chk("bp_hold_imm", {imm32, imm64[31:0]}, {32'h1, 32'h1});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("bp_hold_imm2", {imm32, imm64[31:0]}, {32'h1, 32'h1});
    out_ready = 1'b1;
    for (int n = 0; n < 50 && !bp_done; n++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_done", {63'b0, bp_done}, 64'h1);
    idle(1);
    drain();

    // Flush with count 2 and a concurrent illegal push attempt
    out_ready = 1'b0;
    push(32'h00100093, 64'h0, 3'b000, 32'h1, 32'h1, 64'h1, 64'h1);
    push(32'h00200093, 64'h0, 3'b000, 32'h2, 32'h2, 64'h2, 64'h2);
    flush    = 1'b1;
    instr    = 32'hFFFFFFFF;
    imm_src  = 3'b111;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    chk("flush2_valid", {62'b0, vld32, vld64}, 64'h0);
    chk("flush2_ready", {62'b0, rdy32, rdy64}, 64'h3);
    chk("flush2_ecnt", {ecnt32, ecnt64}, {exp_ecnt[7:0], exp_ecnt[7:0]});

    // Flush with count 1: the accepted-looking illegal push must not count
    push(32'h00100093, 64'h0, 3'b000, 32'h1, 32'h1, 64'h1, 64'h1);
    flush    = 1'b1;
    instr    = 32'hFFFFFFFF;
    imm_src  = 3'b111;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    chk("flush1_valid", {62'b0, vld32, vld64}, 64'h0);
    chk("flush1_ecnt", {ecnt32, ecnt64}, {exp_ecnt[7:0], exp_ecnt[7:0]});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("flush1_still_empty", {62'b0, vld32, vld64}, 64'h0);

    // Asynchronous reset mid-cycle with one entry buffered
    push(32'h00500093, 64'h20, 3'b000, 32'h5, 32'h25, 64'h5, 64'h25);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {62'b0, vld32, vld64}, 64'h0);
    chk("arst_imm", {imm32, imm64[31:0]} | imm64, 64'h0);
    chk("arst_tgt", {tgt32, tgt64[31:0]} | tgt64, 64'h0);
    chk("arst_err", {46'b0, ierr32, ierr64, ecnt32, ecnt64}, 64'h0);
    chk("arst_ready", {62'b0, rdy32, rdy64}, 64'h3);
    q32.delete();
    q64.delete();
    exp_ecnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h00700093, 64'h8, 3'b000, 32'h7, 32'hF, 64'h7, 64'hF);
    chk("post_rst_valid", {62'b0, vld32, vld64}, 64'h3);
    idle(1);
    drain();

    // Saturating illegal-format counter
    for (int k = 0; k < 300; k++) begin
      push(32'hFFFFFFFF, 64'(k), 3'b111, 32'h0, 32'(k), 64'h0, 64'(k));
    end
    idle(2);
    drain();
    chk("ecnt_sat32", {56'b0, ecnt32}, 64'd255);
    chk("ecnt_sat64", {56'b0, ecnt64}, 64'(exp_ecnt));
    chk("end_empty", {62'b0, vld32, vld64}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
